// File: rtl/nand4_sweep_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand4_sweep_checker_pkg
// Description : Shared widths, vector count and FSM encoding for the sweep.
// Revision    : 1.0
// ============================================================================
package nand4_sweep_checker_pkg;

    localparam int VECTOR_COUNT = 256;
    localparam int OPERAND_W    = 4;
    localparam int COUNT_W      = 9;
    localparam int INDEX_W      = 8;
    localparam int SETTLE_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nand4_sweep_checker_ref.sv
`default_nettype none
// ============================================================================
// Module      : nand4_ref_model
// Description : Combinational golden 4-bit NAND used as the expected result.
// Revision    : 1.0
// ============================================================================
module nand4_ref_model
    import nand4_sweep_checker_pkg::*;
(
    input  logic [OPERAND_W-1:0] i_a,
    input  logic [OPERAND_W-1:0] i_b,
    output logic [OPERAND_W-1:0] o_y
);

    assign o_y = ~(i_a & i_b);

endmodule
`default_nettype wire

// File: rtl/nand4_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : nand4_sweep_checker
// Description : Exhaustive 256-vector sweep of an external 4-bit NAND.
// Revision    : 1.0
// ============================================================================
module nand4_sweep_checker
    import nand4_sweep_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [OPERAND_W-1:0] a_out,
    output logic [OPERAND_W-1:0] b_out,
    input  logic [OPERAND_W-1:0] y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [COUNT_W-1:0]   err_count,
    output logic [OPERAND_W-1:0] fail_a,
    output logic [OPERAND_W-1:0] fail_b
);

    localparam logic [SETTLE_W-1:0] c_settle_last = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [INDEX_W-1:0]  c_last_index  = INDEX_W'(VECTOR_COUNT - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [INDEX_W-1:0]     r_idx;
    logic [SETTLE_W-1:0]    r_settle;
    logic [COUNT_W-1:0]     r_err;
    logic [OPERAND_W-1:0]   r_fail_a;
    logic [OPERAND_W-1:0]   r_fail_b;
    logic [OPERAND_W-1:0]   w_expected;
    logic                   w_start_ok;
    logic                   w_settled;
    logic                   w_last;
    logic                   w_mismatch;

    // Operands come straight from the index so IDLE shows 0 and DONE holds F,F.
    assign a_out = r_idx[INDEX_W-1:OPERAND_W];
    assign b_out = r_idx[OPERAND_W-1:0];

    nand4_ref_model u_ref (
        .i_a (a_out),
        .i_b (b_out),
        .o_y (w_expected)
    );

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_settled  = (r_settle == c_settle_last);
    assign w_last     = (r_idx == c_last_index);
    assign w_mismatch = (y_in != w_expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_ok) w_next_state = ST_DRIVE;
            ST_DRIVE:         if (w_settled)  w_next_state = ST_CHECK;
            ST_CHECK:         w_next_state = w_last ? ST_DONE : ST_DRIVE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_idx    <= '0;
                        r_settle <= '0;
                        r_err    <= '0;
                        r_fail_a <= '0;
                        r_fail_b <= '0;
                    end
                end
                ST_DRIVE: begin
                    r_settle <= w_settled ? '0 : r_settle + SETTLE_W'(1);
                end
                ST_CHECK: begin
                    // At most 256 failures, so the 9-bit count cannot wrap.
                    if (w_mismatch) begin
                        r_err <= r_err + COUNT_W'(1);
                        if (r_err == '0) begin
                            r_fail_a <= a_out;
                            r_fail_b <= b_out;
                        end
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + INDEX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass      = done && (r_err == '0);
    assign err_count = r_err;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;

endmodule
`default_nettype wire

// File: tb/tb_nand4_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand4_sweep_checker
// Description : Scoreboard bench driving faulty NAND models into the checker.
// Revision    : 1.0
// ============================================================================
module tb_nand4_sweep_checker;

    localparam int SETTLE  = 1;
    localparam int LATENCY = 256 * (SETTLE + 1) + 1;

    typedef struct {
        int         err;
        logic [3:0] fa;
        logic [3:0] fb;
        logic       pass_v;
        int         accept;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a_out, b_out, y_in, fail_a, fail_b;
    logic       busy, done, pass;
    logic [8:0] err_count;

    logic [2:0] mode;
    logic [3:0] mask_tab [256];
    exp_t       sb [$];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    logic       done_q = 1'b0;

    nand4_sweep_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_out     (a_out),
        .b_out     (b_out),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Device-under-test stand-in: 0 good, 1 bit0 stuck-0, 2 AND, 3 bad at F,F, 4 random flips
    function automatic logic [3:0] fault_y(input logic [3:0] a, input logic [3:0] b, input logic [2:0] m);
        logic [3:0] good;
        good = ~(a & b);
        case (m)
            3'd1:    return good & 4'b1110;
            3'd2:    return a & b;
            3'd3:    return (a == 4'hF && b == 4'hF) ? 4'hF : good;
            3'd4:    return good ^ mask_tab[{a, b}];
            default: return good;
        endcase
    endfunction

    assign y_in = fault_y(a_out, b_out, mode);

    function automatic exp_t model(input logic [2:0] m);
        exp_t       e;
        logic [3:0] a, b;
        e.err = 0; e.fa = 4'h0; e.fb = 4'h0; e.accept = 0;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i / 16);
            b = 4'(i % 16);
            if (fault_y(a, b, m) != ~(a & b)) begin
                if (e.err == 0) begin
                    e.fa = a;
                    e.fb = b;
                end
                e.err++;
            end
        end
        e.pass_v = (e.err == 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic randomize_masks();
        for (int i = 0; i < 256; i++)
            mask_tab[i] = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
    endtask

    // Called at a negedge: the following posedge is the accept edge.
    task automatic do_start(input logic [2:0] m);
        exp_t e;
        mode     = m;
        e        = model(m);
        e.accept = cyc + 1;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 4 * LATENCY) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Latency counts edges inclusively from the accept edge to the edge that raises done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done && !done_q) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check("err_count", {23'd0, err_count}, e.err);
                check("fail_a",    {28'd0, fail_a},    {28'd0, e.fa});
                check("fail_b",    {28'd0, fail_b},    {28'd0, e.fb});
                check("pass",      {31'd0, pass},      {31'd0, e.pass_v});
                check("latency",   cyc - e.accept + 1, LATENCY);
            end
        end
        done_q = done;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},    {28'd0, a_out},  0);
        check({tag, "_b"},    {28'd0, b_out},  0);
        check({tag, "_busy"}, {31'd0, busy},   0);
        check({tag, "_done"}, {31'd0, done},   0);
        check({tag, "_pass"}, {31'd0, pass},   0);
        check({tag, "_err"},  {23'd0, err_count}, 0);
        check({tag, "_fa"},   {28'd0, fail_a}, 0);
        check({tag, "_fb"},   {28'd0, fail_b}, 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 3'd0;
        randomize_masks();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Good NAND, then done held with operands parked at F,F
        do_start(3'd0);
        check("busy_after_start", {31'd0, busy}, 1);
        wait_done();
        repeat (5) @(negedge clk);
        check("done_held", {31'd0, done}, 1);
        check("done_a_ff", {28'd0, a_out}, 32'hF);
        check("done_b_ff", {28'd0, b_out}, 32'hF);

        // Restart from DONE clears results
        do_start(3'd1);
        check("restart_err_clr", {23'd0, err_count}, 0);
        check("restart_done_clr", {31'd0, done}, 0);
        wait_done();
        check("stuck0_count", {23'd0, err_count}, 192);

        do_start(3'd2);
        wait_done();
        check("and_count", {23'd0, err_count}, 256);

        do_start(3'd3);
        wait_done();
        check("ff_count", {23'd0, err_count}, 1);
        check("ff_fail_a", {28'd0, fail_a}, 32'hF);

        // Start re-pulsed while busy must not restart the sweep
        do_start(3'd3);
        repeat (37) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset mid-sweep at vector 100
        randomize_masks();
        do_start(3'd4);
        n = 0;
        while ({a_out, b_out} != 8'd100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec100", {24'd0, a_out, b_out}, 100);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        check_all_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        do_start(3'd4);
        wait_done();

        // Randomized fault patterns
        for (int k = 0; k < 3; k++) begin
            randomize_masks();
            do_start(3'($urandom_range(4)));
            wait_done();
        end

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
